triangle_normal_stream: RTL and testbench
=========================================

TRIANGLE_NORMAL_STREAM -- requirements
Module: triangle_normal_stream

Interface
REQ-001 SHALL have parameter W, default 16: signed fixed-point vertex coordinate width.
REQ-002 SHALL have parameter TAG_W, default 8: width of the per-triangle sideband tag.
REQ-003 SHALL have parameter DEPTH, default 4: output buffer entries; power of two, at least 4.
REQ-004 SHALL derive NW = 2*W+3, the full-precision width of each normal component.
REQ-005 SHALL have ports: clk, input, 1, rising-edge clock; rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports: in_valid, input, 1, triangle offered; in_ready, output, 1, triangle accepted when both high.
REQ-007 SHALL have port in_tri, input, 9*W, packed {p3z,p3y,p3x,p2z,p2y,p2x,p1z,p1y,p1x}, with p1x in the LSBs.
REQ-008 SHALL have port in_tag, input, TAG_W, opaque ID carried with the triangle.
REQ-009 SHALL have ports: out_valid, output, 1; out_ready, input, 1; out_normal, output, 3*NW, packed {nz,ny,nx}; out_tag, output, TAG_W.
REQ-010 SHALL have ports: out_degenerate, output, 1, high when nx=ny=nz=0; cull_count, output, 16, count of culled triangles.

Function
REQ-011 SHALL compute u=p2-p1 and v=p3-p1, each component W+1 bits, sign-extended.
REQ-012 SHALL compute nx=uy*vz-uz*vy, ny=uz*vx-ux*vz, nz=ux*vy-uy*vx, signed, exact, NW bits, with no rounding or saturation.
REQ-013 SHALL be a 3-stage pipeline: S1 subtract, S2 six products, S3 final subtract and push into the output FIFO.
REQ-014 SHALL never stall the pipeline; each stage carries a valid bit, plus the tag and the degenerate flag.
REQ-015 SHALL drive in_ready = (fifo_count + inflight) < DEPTH, where inflight = number of valid S1..S2 stages; this is a credit scheme, so the FIFO can never overflow.
REQ-016 SHALL, with out_ready held high and the FIFO empty, assert out_valid exactly 3 cycles after the accepting edge.
REQ-017 SHALL present the FIFO head on out_valid/out_normal/out_tag/out_degenerate and pop it on out_valid&&out_ready.
REQ-018 SHALL hold out_* stable while out_valid && !out_ready.
REQ-019 SHALL allow push and pop in the same cycle when the FIFO is full; the count is unchanged.
REQ-020 SHALL preserve strict input order and bind each tag to its own triangle.
REQ-021 SHALL sustain 1 triangle/cycle when out_ready is continuously high.
REQ-022 SHALL pass a degenerate triangle (zero normal) through, with out_degenerate=1.

Reset
REQ-023 SHALL, while rst is low, clear all stage valids, the FIFO pointers and count, and cull_count.
REQ-024 SHALL drive, in reset, out_valid=0, in_ready=0, out_normal=0, out_tag=0, out_degenerate=0, cull_count=0.
REQ-025 SHALL discard in-flight and buffered triangles on reset mid-stream; none emerge after release.
REQ-026 SHALL raise in_ready on the first clk edge after rst deasserts.

Configuration
REQ-027 SHALL, with TRI_NORMAL_CULL_EN defined, drop at S3 every triangle with nz<=0 (back-facing or edge-on); a dropped triangle is not pushed to the FIFO, releases its credit, and increments cull_count, which saturates at 16'hFFFF.
REQ-028 SHALL, without TRI_NORMAL_CULL_EN, emit every triangle, tie cull_count to 0, and contain no compare logic.

Structure
REQ-029 SHALL take from package types: localparam TN_LATENCY=3 and the function tn_nw(W)=2*W+3; the bench uses both.
REQ-030 SHALL implement the output buffer as a sub-module normal_fifo (parameters WIDTH, DEPTH; count output; asynchronous active-low reset); the arithmetic stays in the top module.

Verification
REQ-031 SHALL cover: p1=(0,0,0), p2=(1,0,0), p3=(0,1,0), tag 5, out_ready=1 -> normal (0,0,1), tag 5, out_valid 3 cycles after accept.
REQ-032 SHALL cover: p2 and p3 of REQ-031 swapped -> (0,0,-1) without the macro; with TRI_NORMAL_CULL_EN, no output and cull_count=1.
REQ-033 SHALL cover: collinear (0,0,0),(1,1,1),(2,2,2) -> (0,0,0), out_degenerate=1, emitted even with the macro.
REQ-034 SHALL cover: out_ready=0 with 10 triangles offered -> exactly DEPTH accepted, then in_ready=0; after release, all 10 emerge in order with matching tags.
REQ-035 SHALL cover: W=16, p1=(-32768,-32768,-32768), p2=(32767,-32768,-32768), p3=(-32768,32767,-32768) -> nz=65535*65535=4294836225, nx=ny=0, no overflow.
REQ-036 SHALL cover: rst low for 1 cycle with 3 triangles in flight and 2 buffered -> out_valid=0, no stale output after release, cull_count=0.

Source files
------------

// File: rtl/triangle_normal_stream_pkg.sv
// triangle_normal_stream_pkg
// Shared constants for the triangle normal pipeline.
//   TN_LATENCY : cycles from the accepting cycle to out_valid when the output
//                buffer is empty and out_ready is high.
//   tn_nw(w)   : full-precision width of one normal component for a w-bit
//                signed vertex coordinate (two (w+1)-bit operand products,
//                plus one bit for their difference).
package triangle_normal_stream_pkg;

    localparam int TN_LATENCY = 3;

    function automatic int tn_nw(input int w);
        return 2 * w + 3;
    endfunction

endpackage

// File: rtl/triangle_normal_stream_fifo.sv
// normal_fifo
// Output buffer for finished normals. The head entry is presented
// combinationally. Push and pop may happen in the same cycle, including when
// the buffer is full; in that case the count does not change.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset (clears pointers and count)
//   push      : write push_data at the tail
//   push_data : entry to store
//   pop       : drop the head entry (ignored when empty)
//   head_data : current head entry (meaningful while count != 0)
//   count     : number of stored entries, 0..DEPTH
module normal_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        do_pop   = pop && (count_q != '0);
        // A push into a full buffer is legal only when the head leaves in the
        // same cycle; the slot being written is the one being vacated.
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read while count is zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/triangle_normal_stream.sv
// triangle_normal_stream
// Streams triangles in and face normals out: n = (p2-p1) x (p3-p1), exact.
// Pipeline: S1 registers edge vectors u,v; S2 registers the six products;
// S3 forms the differences and pushes into an output buffer (normal_fifo).
// The pipeline never stalls; admission is governed by credits so that the
// buffer cannot overflow.
// Optional feature macro: TRI_NORMAL_CULL_EN drops triangles with nz <= 0
// (degenerate triangles are always emitted) and counts them in cull_count.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   in_valid/ready  : triangle handshake; in_tri {p3z..p1x}, in_tag sideband
//   out_valid/ready : normal handshake; out_normal {nz,ny,nx}, out_tag,
//                     out_degenerate (all components zero)
//   cull_count      : saturating count of culled triangles (0 without macro)
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a producer holds data stable while valid is high and ready is
// low, and ready may depend on internal state only.
module triangle_normal_stream
    import triangle_normal_stream_pkg::*;
#(
    parameter  int W     = 16,
    parameter  int TAG_W = 8,
    parameter  int DEPTH = 4,
    localparam int NW    = tn_nw(W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [9*W-1:0]    in_tri,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3*NW-1:0]   out_normal,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_degenerate,
    output logic [15:0]       cull_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = 2 * W + 2;
    localparam int EW = 1 + TAG_W + 3 * NW;

    logic signed [W-1:0]  crd [9];
    logic signed [W:0]    diff_d [6];     // ux, uy, uz, vx, vy, vz
    logic signed [W:0]    s1_diff_q [6];
    logic                 s1_valid_q, s1_valid_d;
    logic [TAG_W-1:0]     s1_tag_q, s1_tag_d;
    logic signed [PW-1:0] prod_d [6];
    logic signed [PW-1:0] s2_prod_q [6];
    logic                 s2_valid_q, s2_valid_d;
    logic [TAG_W-1:0]     s2_tag_q, s2_tag_d;
    logic                 rdy_en_q, rdy_en_d;
    logic signed [NW-1:0] nx, ny, nz;
    logic                 degenerate;
    logic                 cull;
    logic                 push;
    logic                 pop;
    logic [CW-1:0]        fifo_count;
    logic [CW:0]          credit_used;
    logic [EW-1:0]        head;

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            crd[k] = in_tri[k*W +: W];
        end
    end

    always_comb begin
        s1_valid_d = in_valid && in_ready;
        s1_tag_d   = in_tag;
        for (int c = 0; c < 3; c++) begin
            diff_d[c]     = (W+1)'(crd[3+c]) - (W+1)'(crd[c]);
            diff_d[3 + c] = (W+1)'(crd[6+c]) - (W+1)'(crd[c]);
        end
        s2_valid_d = s1_valid_q;
        s2_tag_d   = s1_tag_q;
        prod_d[0]  = PW'(s1_diff_q[1]) * PW'(s1_diff_q[5]);   // uy*vz
        prod_d[1]  = PW'(s1_diff_q[2]) * PW'(s1_diff_q[4]);   // uz*vy
        prod_d[2]  = PW'(s1_diff_q[2]) * PW'(s1_diff_q[3]);   // uz*vx
        prod_d[3]  = PW'(s1_diff_q[0]) * PW'(s1_diff_q[5]);   // ux*vz
        prod_d[4]  = PW'(s1_diff_q[0]) * PW'(s1_diff_q[4]);   // ux*vy
        prod_d[5]  = PW'(s1_diff_q[1]) * PW'(s1_diff_q[3]);   // uy*vx
        // Input side opens on the first edge after reset release.
        rdy_en_d   = 1'b1;
    end

    always_comb begin
        nx         = NW'(s2_prod_q[0]) - NW'(s2_prod_q[1]);
        ny         = NW'(s2_prod_q[2]) - NW'(s2_prod_q[3]);
        nz         = NW'(s2_prod_q[4]) - NW'(s2_prod_q[5]);
        degenerate = (nx == '0) && (ny == '0) && (nz == '0);
    end

`ifdef TRI_NORMAL_CULL_EN
    logic [15:0] cull_count_q, cull_count_d;

    always_comb begin
        // nz <= 0 is back-facing or edge-on; a zero normal is still emitted.
        cull         = s2_valid_q && !degenerate && (nz[NW-1] || (nz == '0));
        cull_count_d = cull_count_q;
        if (cull && (cull_count_q != 16'hFFFF)) begin
            cull_count_d = cull_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cull_count_q <= '0;
        end else begin
            cull_count_q <= cull_count_d;
        end
    end

    assign cull_count = cull_count_q;
`else
    assign cull       = 1'b0;
    assign cull_count = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            rdy_en_q   <= 1'b0;
            s1_tag_q   <= '0;
            s2_tag_q   <= '0;
            for (int k = 0; k < 6; k++) begin
                s1_diff_q[k] <= '0;
                s2_prod_q[k] <= '0;
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            rdy_en_q   <= rdy_en_d;
            s1_tag_q   <= s1_tag_d;
            s2_tag_q   <= s2_tag_d;
            for (int k = 0; k < 6; k++) begin
                s1_diff_q[k] <= diff_d[k];
                s2_prod_q[k] <= prod_d[k];
            end
        end
    end

    // Every triangle in S1/S2 holds a reserved buffer slot, so a push can
    // never find the buffer full without a simultaneous pop.
    assign credit_used = (CW+1)'(fifo_count) + (CW+1)'(s1_valid_q) + (CW+1)'(s2_valid_q);
    assign in_ready    = rdy_en_q && (credit_used < (CW+1)'(DEPTH));
    assign push        = s2_valid_q && !cull;
    assign out_valid   = (fifo_count != '0);
    assign pop         = out_valid && out_ready;

    normal_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({degenerate, s2_tag_q, nz, ny, nx}),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_count)
    );

    // Outputs read as zero whenever the buffer is empty, including in reset.
    assign {out_degenerate, out_tag, out_normal} = out_valid ? head : '0;

endmodule

// File: tb/tb_triangle_normal_stream.sv
module tb_triangle_normal_stream;
    import triangle_normal_stream_pkg::*;

    localparam int W     = 16;
    localparam int TAG_W = 8;
    localparam int DEPTH = 4;
    localparam int NW    = tn_nw(W);
    localparam int EW    = 1 + TAG_W + 3 * NW;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [9*W-1:0]    in_tri;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [3*NW-1:0]   out_normal;
    logic [TAG_W-1:0]  out_tag;
    logic              out_degenerate;
    logic [15:0]       cull_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc;
    int n_out = 0;
    int exp_cull = 0;
    logic [EW-1:0] exp_q[$];
    bit            prev_stall = 0;
    logic [EW-1:0] prev_out;

    triangle_normal_stream #(.W(W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_tri         (in_tri),
        .in_tag         (in_tag),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_normal     (out_normal),
        .out_tag        (out_tag),
        .out_degenerate (out_degenerate),
        .cull_count     (cull_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_true(input string name, input bit ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0 expected 1", name);
        end
    endtask

    task automatic check_vec(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [9*W-1:0] mk_tri(input int p1x, input int p1y, input int p1z,
                                              input int p2x, input int p2y, input int p2z,
                                              input int p3x, input int p3y, input int p3z);
        return {W'(p3z), W'(p3y), W'(p3x), W'(p2z), W'(p2y), W'(p2x), W'(p1z), W'(p1y), W'(p1x)};
    endfunction

    // Front-facing triangles by construction: u=(a,0,c), v=(0,b,d), nz=a*b>0.
    function automatic logic [9*W-1:0] gen_tri(input int i);
        int bx, by, bz, a, b, c, d;
        bx = i * 3 - 7;  by = 11 - 2 * i;  bz = i * 5;
        a = 1 + i % 5;   b = 2 + i % 3;    c = i - 4;  d = 3 - i;
        return mk_tri(bx, by, bz, bx + a, by, bz + c, bx, by + b, bz + d);
    endfunction

    function automatic longint comp(input logic [3*NW-1:0] v, input int k);
        logic signed [NW-1:0] t;
        t = v[k*NW +: NW];
        return longint'(t);
    endfunction

    // Reference model: cross product in 64-bit integer arithmetic.
    function automatic logic [EW-1:0] model_entry(input logic [9*W-1:0] t, input logic [TAG_W-1:0] tag);
        longint p[9];
        longint ux, uy, uz, vx, vy, vz, nx, ny, nz;
        logic   dg;
        for (int k = 0; k < 9; k++) begin
            logic signed [W-1:0] c;
            c    = t[k*W +: W];
            p[k] = longint'(c);
        end
        ux = p[3] - p[0];  uy = p[4] - p[1];  uz = p[5] - p[2];
        vx = p[6] - p[0];  vy = p[7] - p[1];  vz = p[8] - p[2];
        nx = uy * vz - uz * vy;
        ny = uz * vx - ux * vz;
        nz = ux * vy - uy * vx;
        dg = (nx == 0) && (ny == 0) && (nz == 0);
        return {dg, tag, nz[NW-1:0], ny[NW-1:0], nx[NW-1:0]};
    endfunction

`ifdef TRI_NORMAL_CULL_EN
    function automatic bit model_culled(input logic [EW-1:0] e);
        logic signed [NW-1:0] nz;
        nz = e[3*NW-1:2*NW];
        return !e[EW-1] && (nz <= 0);
    endfunction
`endif

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic drive(input logic [9*W-1:0] t, input logic [TAG_W-1:0] tag);
        bit hs;
        int n;
        hs = 0;
        n  = 0;
        in_tri   = t;
        in_tag   = tag;
        in_valid = 1'b1;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = in_ready;
            if (hs) acc_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        check_true("accepted", hs);
    endtask

    // Returns at the negedge where out_valid is first seen high.
    task automatic wait_out();
        bit ok;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (out_valid) ok = 1;
        end
        check_true("out_valid_seen", ok);
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int n = 0; n < 80 && !ok; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) ok = 1;
        end
        check_true("drain", ok);
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        logic [EW-1:0] cur;
        logic [EW-1:0] e;
        cur = {out_degenerate, out_tag, out_normal};
        if (!rst) begin
            exp_q.delete();
            exp_cull   = 0;
            prev_stall = 0;
        end else begin
            if (in_valid && in_ready) begin
                e = model_entry(in_tri, in_tag);
`ifdef TRI_NORMAL_CULL_EN
                if (model_culled(e)) exp_cull++;
                else exp_q.push_back(e);
`else
                exp_q.push_back(e);
`endif
            end
            if (prev_stall) check_vec("hold_stable", cur, prev_out);
            if (out_valid && out_ready) begin
                n_out++;
                check_true("out_expected", exp_q.size() != 0);
                if (exp_q.size() != 0) check_vec("out_entry", cur, exp_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = cur;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n0, first, idx;
        bit hs;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_tri    = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        #2 rst = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_normal", out_normal, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_degen", out_degenerate, 0);
        check("rst_cull_count", cull_count, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        check("ready_after_edge", in_ready, 1);

        // Basic normal (0,0,1) and latency
        drive(mk_tri(0, 0, 0, 1, 0, 0, 0, 1, 0), 8'd5);
        in_valid = 1'b0;
        wait_out();
        check("latency", cyc - acc_cyc, TN_LATENCY);
        check("basic_nx", comp(out_normal, 0), 0);
        check("basic_ny", comp(out_normal, 1), 0);
        check("basic_nz", comp(out_normal, 2), 1);
        check("basic_tag", out_tag, 5);
        check("basic_degen", out_degenerate, 0);
        @(posedge clk);
        #1;

        // Swapped winding
        n0 = n_out;
        drive(mk_tri(0, 0, 0, 0, 1, 0, 1, 0, 0), 8'd6);
        in_valid = 1'b0;
`ifdef TRI_NORMAL_CULL_EN
        repeat (8) @(negedge clk);
        check("swap_cull_count", cull_count, 1);
        check("swap_no_output", n_out - n0, 0);
`else
        wait_out();
        check("swap_nz", comp(out_normal, 2), -1);
        check("swap_tag", out_tag, 6);
        check("swap_cull_count", cull_count, 0);
`endif
        @(posedge clk);
        #1;

        // Collinear -> degenerate, always emitted
        drive(mk_tri(0, 0, 0, 1, 1, 1, 2, 2, 2), 8'd7);
        in_valid = 1'b0;
        wait_out();
        check("degen_flag", out_degenerate, 1);
        check("degen_normal", out_normal, 0);
        check("degen_tag", out_tag, 7);
        @(posedge clk);
        #1;

        // Extreme coordinates
        drive(mk_tri(-32768, -32768, -32768, 32767, -32768, -32768, -32768, 32767, -32768), 8'd9);
        in_valid = 1'b0;
        wait_out();
        check("ext_nx", comp(out_normal, 0), 0);
        check("ext_ny", comp(out_normal, 1), 0);
        check("ext_nz", comp(out_normal, 2), 64'sd4294836225);
        @(posedge clk);
        #1;

        // Back-to-back stream at full rate
        wait_drain();
        n0 = n_out;
        first = 0;
        for (int i = 0; i < 8; i++) begin
            drive(gen_tri(20 + i), TAG_W'(8'h80 + i));
            if (i == 0) first = acc_cyc;
        end
        in_valid = 1'b0;
        check("stream_spacing", acc_cyc - first, 7);
        wait_drain();
        check("stream_count", n_out - n0, 8);

        // Backpressure: 10 offered, DEPTH admitted while out_ready is low
        n0 = n_out;
        out_ready = 1'b0;
        idx = 0;
        in_tri = gen_tri(0);
        in_tag = TAG_W'(8'h40);
        in_valid = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                idx++;
                in_tri = gen_tri(idx);
                in_tag = TAG_W'(8'h40 + idx);
            end
        end
        check("stall_accepted", idx, DEPTH);
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int c = 0; c < 100 && idx < 10; c++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                idx++;
                in_tri = gen_tri(idx);
                in_tag = TAG_W'(8'h40 + idx);
            end
        end
        in_valid = 1'b0;
        check("stall_all_accepted", idx, 10);
        wait_drain();
        check("stall_count", n_out - n0, 10);

        // Reset mid-stream: 2 buffered, 2 in stages, 1 waiting at the input
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive(gen_tri(30 + i), TAG_W'(8'hC0 + i));
        in_tri = gen_tri(34);
        in_tag = TAG_W'(8'hC4);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_cull_count", cull_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n0 = n_out;
        repeat (10) @(negedge clk);
        check("no_stale_output", n_out - n0, 0);
        check("post_rst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;

        // One fresh triangle after recovery
        drive(gen_tri(50), TAG_W'(8'h55));
        in_valid = 1'b0;
        wait_drain();
        check("post_rst_count", n_out - n0, 1);
        check("final_cull_count", cull_count, exp_cull);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
